// File: rtl/inst_line_buffer.sv
// inst_line_buffer: single-line instruction buffer in front of an AXI-style
// burst read port.
//   Core side : INST_RDEN/INST_RIADDR in; INST_RVALID/INST_ROADDR/INST_RDATA
//               out (registered, one cycle after a hit); MEM_WAIT out
//               (combinational stall request).
//   Memory    : M_AR* request channel, M_R* data channel, one burst of
//               LINE_WORDS beats per refill.
//   Control   : CLK, RST (async active-high), INVALIDATE (drop the line),
//               FILL_ERR (pulse when a burst ends with the wrong beat count).
module inst_line_buffer #(
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INVALIDATE,
  input  logic        INST_RDEN,
  input  logic [31:0] INST_RIADDR,
  output logic [31:0] INST_ROADDR,
  output logic        INST_RVALID,
  output logic [31:0] INST_RDATA,
  output logic        MEM_WAIT,
  output logic        M_ARVALID,
  input  logic        M_ARREADY,
  output logic [31:0] M_ARADDR,
  output logic [7:0]  M_ARLEN,
  input  logic        M_RVALID,
  output logic        M_RREADY,
  input  logic [31:0] M_RDATA,
  input  logic        M_RLAST,
  output logic        FILL_ERR
);

  localparam int unsigned IW  = $clog2(LINE_WORDS);
  localparam int unsigned OFS = IW + 2;
  localparam int unsigned TW  = 32 - OFS;
  localparam int unsigned CW  = IW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_RDATA,
    S_DONE
  } state_t;

  state_t          state_q;
  logic            line_valid_q;
  logic            inv_pend_q;
  logic [TW-1:0]   tag_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     line_q [LINE_WORDS];

  logic            rvalid_q;
  logic [31:0]     roaddr_q;
  logic [31:0]     rdata_q;
  logic            arvalid_q;
  logic [31:0]     araddr_q;
  logic            rready_q;
  logic            fill_err_q;

  logic [TW-1:0]   req_tag_c;
  logic [IW-1:0]   req_idx_c;
  logic            hit_c;
  logic            cnt_full_c;
  logic            cnt_last_c;
  logic            beat_c;

  assign req_tag_c  = INST_RIADDR[31:OFS];
  assign req_idx_c  = INST_RIADDR[OFS-1:2];
  assign hit_c      = INST_RDEN && line_valid_q && (tag_q == req_tag_c) && (state_q == S_IDLE);
  // cnt saturates at LINE_WORDS; a saturated count means extra beats are dropped
  assign cnt_full_c = (cnt_q == CW'(LINE_WORDS));
  assign cnt_last_c = (cnt_q == CW'(LINE_WORDS - 1));
  assign beat_c     = (state_q == S_RDATA) && M_RVALID;

  assign MEM_WAIT    = (state_q != S_IDLE) || (INST_RDEN && !hit_c);
  assign M_ARLEN     = 8'(LINE_WORDS - 1);
  assign INST_RVALID = rvalid_q;
  assign INST_ROADDR = roaddr_q;
  assign INST_RDATA  = rdata_q;
  assign M_ARVALID   = arvalid_q;
  assign M_ARADDR    = araddr_q;
  assign M_RREADY    = rready_q;
  assign FILL_ERR    = fill_err_q;

  // Line storage; contents are qualified by line_valid_q so no reset is needed
  always_ff @(posedge CLK) begin
    if (beat_c && !cnt_full_c) begin
      line_q[cnt_q[IW-1:0]] <= M_RDATA;
    end
  end

  // Refill FSM, fetch response and line bookkeeping
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      line_valid_q <= 1'b0;
      inv_pend_q   <= 1'b0;
      tag_q        <= '0;
      cnt_q        <= '0;
      rvalid_q     <= 1'b0;
      roaddr_q     <= '0;
      rdata_q      <= '0;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      rready_q     <= 1'b0;
      fill_err_q   <= 1'b0;
    end else begin
      fill_err_q <= 1'b0;
      rvalid_q   <= hit_c;
      if (hit_c) begin
        roaddr_q <= INST_RIADDR;
        rdata_q  <= line_q[req_idx_c];
      end

      case (state_q)
        S_IDLE: begin
          if (INST_RDEN && !hit_c) begin
            state_q      <= S_AR;
            araddr_q     <= {req_tag_c, OFS'(0)};
            arvalid_q    <= 1'b1;
            tag_q        <= req_tag_c;
            line_valid_q <= 1'b0;
            cnt_q        <= '0;
            inv_pend_q   <= 1'b0;
          end else if (INVALIDATE) begin
            // a same-cycle hit has already been served from the old line
            line_valid_q <= 1'b0;
          end
        end

        S_AR: begin
          if (INVALIDATE) begin
            inv_pend_q <= 1'b1;
          end
          if (M_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RDATA;
          end
        end

        S_RDATA: begin
          if (INVALIDATE) begin
            inv_pend_q <= 1'b1;
          end
          if (M_RVALID) begin
            if (!cnt_full_c) begin
              cnt_q <= cnt_q + CW'(1);
            end
            if (M_RLAST) begin
              rready_q <= 1'b0;
              state_q  <= S_DONE;
              if (cnt_last_c) begin
                line_valid_q <= !(inv_pend_q || INVALIDATE);
              end else begin
                fill_err_q <= 1'b1;
              end
            end
          end
        end

        S_DONE: begin
          // held request is re-evaluated in IDLE next cycle
          if (INVALIDATE || inv_pend_q) begin
            line_valid_q <= 1'b0;
          end
          inv_pend_q <= 1'b0;
          state_q    <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_line_buffer.sv
// Bench for inst_line_buffer (LINE_WORDS=4): burst-memory responder with
// configurable ARREADY delay, RVALID gaps and short bursts, a per-cycle
// checker for response data/address and AR-channel behaviour, and directed
// scenarios with hand-computed latencies and data.
module tb_inst_line_buffer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        INST_RDEN = 1'b0;
  logic [31:0] INST_RIADDR = '0;
  logic [31:0] INST_ROADDR;
  logic        INST_RVALID;
  logic [31:0] INST_RDATA;
  logic        MEM_WAIT;
  logic        M_ARVALID;
  logic        M_ARREADY = 1'b0;
  logic [31:0] M_ARADDR;
  logic [7:0]  M_ARLEN;
  logic        M_RVALID = 1'b0;
  logic        M_RREADY;
  logic [31:0] M_RDATA = '0;
  logic        M_RLAST = 1'b0;
  logic        FILL_ERR;
  logic        inv_main = 1'b0;
  logic        inv_slave = 1'b0;
  wire         INVALIDATE = inv_main | inv_slave;

  inst_line_buffer #(.LINE_WORDS(4)) dut (
    .CLK(CLK), .RST(RST), .INVALIDATE(INVALIDATE),
    .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR),
    .INST_ROADDR(INST_ROADDR), .INST_RVALID(INST_RVALID), .INST_RDATA(INST_RDATA),
    .MEM_WAIT(MEM_WAIT),
    .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA), .M_RLAST(M_RLAST),
    .FILL_ERR(FILL_ERR)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // responder configuration and observations
  int          ar_delay = 0;
  int          r_gap = 0;
  int          short_left = 0;
  bit          inv_on_beat2 = 1'b0;
  int          phase = 0;
  int          ar_wait = 0;
  int          beat = 0;
  int          gap = 0;
  int          nbeats = 4;
  logic [31:0] burst_addr = '0;
  logic [31:0] last_araddr = '0;
  int          ar_cnt = 0;
  int          err_cnt = 0;

  logic        prev_rden = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        prev_arvalid = 1'b0;
  logic [31:0] prev_araddr = '0;

  // Per-cycle checker followed by the memory responder, both on the falling edge
  initial forever begin
    @(negedge CLK);
    if (RST) begin
      prev_rden    = 1'b0;
      prev_arvalid = 1'b0;
      phase        = 0;
      ar_wait      = 0;
      M_ARREADY    = 1'b0;
      M_RVALID     = 1'b0;
      M_RLAST      = 1'b0;
      inv_slave    = 1'b0;
    end else begin
      if (INST_RVALID) begin
        check("rvalid_had_req", 32'(prev_rden), 32'd1);
        check("roaddr_echo", INST_ROADDR, prev_addr);
        check("rdata_mem", INST_RDATA, mem_word(INST_ROADDR));
      end
      if (M_ARVALID || M_RREADY) check("memwait_busy", 32'(MEM_WAIT), 32'd1);
      if (M_ARVALID) begin
        check("arlen", 32'(M_ARLEN), 32'd3);
        check("araddr_align", M_ARADDR & 32'hF, 32'd0);
      end
      if (prev_arvalid && !M_ARREADY) begin
        check("arvalid_hold", 32'(M_ARVALID), 32'd1);
        check("araddr_hold", M_ARADDR, prev_araddr);
      end
      if (FILL_ERR) err_cnt++;
      prev_rden    = INST_RDEN;
      prev_addr    = INST_RIADDR;
      prev_arvalid = M_ARVALID;
      prev_araddr  = M_ARADDR;

      inv_slave = 1'b0;
      if (phase == 0) begin
        if (M_ARVALID) begin
          if (ar_wait < ar_delay) begin
            ar_wait++;
            M_ARREADY = 1'b0;
          end else begin
            M_ARREADY   = 1'b1;
            ar_wait     = 0;
            phase       = 1;
            burst_addr  = M_ARADDR;
            last_araddr = M_ARADDR;
            ar_cnt++;
            beat        = 0;
            gap         = r_gap;
            nbeats      = (short_left > 0) ? 2 : 4;
            if (short_left > 0) short_left--;
          end
        end else begin
          M_ARREADY = 1'b0;
        end
      end else begin
        M_ARREADY = 1'b0;
        if (M_RVALID) begin
          beat++;
          gap      = 0;
          M_RVALID = 1'b0;
          if (M_RLAST) begin
            M_RLAST = 1'b0;
            phase   = 0;
          end
        end
        if (phase == 1 && M_RREADY) begin
          if (gap >= r_gap) begin
            M_RVALID = 1'b1;
            M_RDATA  = mem_word(burst_addr + 32'(4 * beat));
            M_RLAST  = (beat == nbeats - 1);
            if (beat == 2 && inv_on_beat2) begin
              inv_slave    = 1'b1;
              inv_on_beat2 = 1'b0;
            end
          end else begin
            gap++;
          end
        end
      end
    end
  end

  // Present a fetch and hold it until the matching response; cyc counts edges
  task automatic fetch(input logic [31:0] addr, input bit inv,
                       output int cyc, output int nw0, output logic mw0);
    bit done;
    INST_RDEN   = 1'b1;
    INST_RIADDR = addr;
    inv_main    = inv;
    cyc  = 0;
    nw0  = 0;
    done = 1'b0;
    #1;
    mw0 = MEM_WAIT;
    while (!done && cyc < 200) begin
      @(posedge CLK);
      #1;
      inv_main = 1'b0;
      cyc++;
      if (INST_RVALID && INST_ROADDR == addr) done = 1'b1;
      else if (!MEM_WAIT) nw0++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL fetch_timeout: addr=%h got no response after %0d cycles", addr, cyc);
    end
  endtask

  int   cyc, nw0, ar0, err0, w;
  logic mw0;

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("rst_rvalid", 32'(INST_RVALID), 32'd0);
    check("rst_arvalid", 32'(M_ARVALID), 32'd0);
    check("rst_memwait", 32'(MEM_WAIT), 32'd0);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check("idle_memwait", 32'(MEM_WAIT), 32'd0);
    check("idle_roaddr", INST_ROADDR, 32'd0);

    // cold fetch
    fetch(32'h2000_0000, 1'b0, cyc, nw0, mw0);
    check("cold_memwait_now", 32'(mw0), 32'd1);
    check("cold_lat", 32'(cyc), 32'd8);
    check("cold_ar_cnt", 32'(ar_cnt), 32'd1);
    check("cold_araddr", last_araddr, 32'h2000_0000);
    check("cold_rdata", INST_RDATA, 32'h85A5_0000);
    check("cold_arlen", 32'(M_ARLEN), 32'd3);

    // sequential hits
    for (int i = 1; i < 4; i++) begin
      fetch(32'h2000_0000 + 32'(4 * i), 1'b0, cyc, nw0, mw0);
      check("seq_lat", 32'(cyc), 32'd1);
      check("seq_memwait", 32'(mw0), 32'd0);
    end
    check("seq_rdata_last", INST_RDATA, 32'h85A5_000C);
    check("seq_no_ar", 32'(ar_cnt), 32'd1);

    // next line, then the old line is gone
    fetch(32'h2000_0010, 1'b0, cyc, nw0, mw0);
    check("next_lat", 32'(cyc), 32'd8);
    check("next_ar_cnt", 32'(ar_cnt), 32'd2);
    check("next_araddr", last_araddr, 32'h2000_0010);
    fetch(32'h2000_0000, 1'b0, cyc, nw0, mw0);
    check("back_lat", 32'(cyc), 32'd8);
    check("back_ar_cnt", 32'(ar_cnt), 32'd3);

    // slow ARREADY and gapped beats
    ar_delay = 5;
    r_gap    = 2;
    fetch(32'h3000_0008, 1'b0, cyc, nw0, mw0);
    check("slow_lat", 32'(cyc), 32'd19);
    check("slow_wait_gaps", 32'(nw0), 32'd1);
    check("slow_rdata", INST_RDATA, 32'h95A5_0008);
    ar_delay = 0;
    r_gap    = 0;
    fetch(32'h3000_0000, 1'b0, cyc, nw0, mw0);
    check("slow_hit0_lat", 32'(cyc), 32'd1);
    check("slow_hit0_rdata", INST_RDATA, 32'h95A5_0000);
    fetch(32'h3000_000C, 1'b0, cyc, nw0, mw0);
    check("slow_hit3_rdata", INST_RDATA, 32'h95A5_000C);

    // invalidate during the third beat forces a second burst
    inv_on_beat2 = 1'b1;
    ar0 = ar_cnt;
    fetch(32'h4000_0000, 1'b0, cyc, nw0, mw0);
    check("inv_burst_lat", 32'(cyc), 32'd15);
    check("inv_burst_ars", 32'(ar_cnt - ar0), 32'd2);
    check("inv_burst_rdata", INST_RDATA, 32'hE5A5_0000);
    fetch(32'h4000_0004, 1'b0, cyc, nw0, mw0);
    check("inv_burst_hit", 32'(cyc), 32'd1);

    // short burst: error pulse then retry
    short_left = 1;
    ar0  = ar_cnt;
    err0 = err_cnt;
    fetch(32'h5000_0004, 1'b0, cyc, nw0, mw0);
    check("short_lat", 32'(cyc), 32'd13);
    check("short_err", 32'(err_cnt - err0), 32'd1);
    check("short_ars", 32'(ar_cnt - ar0), 32'd2);
    check("short_rdata", INST_RDATA, 32'hF5A5_0004);

    // invalidate while idle
    INST_RDEN = 1'b0;
    inv_main  = 1'b1;
    @(posedge CLK);
    #1;
    inv_main = 1'b0;
    fetch(32'h5000_0008, 1'b0, cyc, nw0, mw0);
    check("idle_inv_lat", 32'(cyc), 32'd8);

    // invalidate together with a hit: hit served, line dropped after
    fetch(32'h5000_000C, 1'b1, cyc, nw0, mw0);
    check("inv_hit_lat", 32'(cyc), 32'd1);
    check("inv_hit_rdata", INST_RDATA, 32'hF5A5_000C);
    fetch(32'h5000_0000, 1'b0, cyc, nw0, mw0);
    check("inv_hit_refill", 32'(cyc), 32'd8);

    // reset in the middle of the data phase
    INST_RDEN   = 1'b1;
    INST_RIADDR = 32'h6000_0000;
    w = 0;
    while (!M_RREADY && w < 50) begin
      @(posedge CLK);
      #1;
      w++;
    end
    check("mid_rready_seen", 32'(M_RREADY), 32'd1);
    #2;
    RST       = 1'b1;
    INST_RDEN = 1'b0;
    #1;
    check("mid_rst_arvalid", 32'(M_ARVALID), 32'd0);
    check("mid_rst_rready", 32'(M_RREADY), 32'd0);
    check("mid_rst_rvalid", 32'(INST_RVALID), 32'd0);
    check("mid_rst_roaddr", INST_ROADDR, 32'd0);
    check("mid_rst_rdata", INST_RDATA, 32'd0);
    check("mid_rst_araddr", M_ARADDR, 32'd0);
    check("mid_rst_memwait", 32'(MEM_WAIT), 32'd0);
    check("mid_rst_fillerr", 32'(FILL_ERR), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    fetch(32'h2000_0000, 1'b0, cyc, nw0, mw0);
    check("post_rst_lat", 32'(cyc), 32'd8);
    check("post_rst_rdata", INST_RDATA, 32'h85A5_0000);

    INST_RDEN = 1'b0;
    repeat (3) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
